// File: rtl/counter_updown_mod.sv
// Up/down counter with programmable upper bound, wrap or saturate at the bounds,
// an enable prescaler, a combinational terminal-count flag and a registered boundary-event pulse.
module counter_updown_mod #(
  parameter int               WIDTH    = 5,
  parameter logic [WIDTH-1:0] MAX_VAL  = '1,
  parameter bit               SATURATE = 1'b0,
  parameter int               PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enab,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt_out,
  output logic             tc,
  output logic             evt
);

  localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [WIDTH:0]   MAX_EXT  = {1'b0, MAX_VAL};
  localparam logic [WIDTH:0]   ONE_EXT  = (WIDTH + 1)'(1);

  logic [PRE_W-1:0] pre;
  logic             step;
  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH-1:0] nxt_val;
  logic             at_bound;
  logic [WIDTH-1:0] load_val;

  assign step     = enab && (pre == PRE_LAST);
  assign cnt_ext  = {1'b0, cnt_out};
  assign load_val = (cnt_in > MAX_VAL) ? MAX_VAL : cnt_in;
  assign tc       = up_dn ? (cnt_out == MAX_VAL) : (cnt_out == '0);

  // Next count for a step; the extra bit keeps MAX_VAL = 2**WIDTH-1 from aliasing on +1.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    nxt_val  = cnt_out;
    at_bound = 1'b0;
    if (up_dn) begin
      if (cnt_ext < MAX_EXT) begin
        nxt_val = WIDTH'(cnt_ext + ONE_EXT);
      end else begin
        at_bound = 1'b1;
        nxt_val  = SATURATE ? MAX_VAL : '0;
      end
    end else begin
      if (cnt_ext != '0) begin
        nxt_val = WIDTH'(cnt_ext - ONE_EXT);
      end else begin
        at_bound = 1'b1;
        nxt_val  = SATURATE ? '0 : MAX_VAL;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      cnt_out <= '0;
      pre     <= '0;
      evt     <= 1'b0;
    end else if (load) begin
      cnt_out <= load_val;
      pre     <= '0;
      evt     <= 1'b0;
    end else if (enab) begin
      pre <= step ? '0 : pre + PRE_ONE;
      evt <= step && at_bound;
      if (step) begin
        cnt_out <= nxt_val;
      end
    end else begin
      evt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Drives three counter configurations with identical stimulus (directed then random)
// and compares each against an integer reference model built from the counting rules.
module tb_counter_updown_mod;

  localparam int N = 3;
  // Configurations: 0 = defaults, 1 = MAX 9 saturating, 2 = prescale 3.
  localparam int CFG_MAX [N] = '{31, 9, 31};
  localparam int CFG_SAT [N] = '{0, 1, 0};
  localparam int CFG_PRE [N] = '{1, 1, 3};

  logic       clk = 1'b0;
  logic       rst_n, load, enab, up_dn;
  logic [4:0] cnt_in;
  logic [4:0] cnt [N];
  logic       tc_o [N];
  logic       evt_o [N];

  int tests = 0;
  int fails = 0;

  int m_cnt [N];
  int m_pre [N];
  int m_evt [N];

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(5)) u_def (
    .clk(clk), .rst_n(rst_n), .load(load), .enab(enab), .up_dn(up_dn),
    .cnt_in(cnt_in), .cnt_out(cnt[0]), .tc(tc_o[0]), .evt(evt_o[0]));

  counter_updown_mod #(.WIDTH(5), .MAX_VAL(5'd9), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .load(load), .enab(enab), .up_dn(up_dn),
    .cnt_in(cnt_in), .cnt_out(cnt[1]), .tc(tc_o[1]), .evt(evt_o[1]));

  counter_updown_mod #(.WIDTH(5), .PRESCALE(3)) u_pre (
    .clk(clk), .rst_n(rst_n), .load(load), .enab(enab), .up_dn(up_dn),
    .cnt_in(cnt_in), .cnt_out(cnt[2]), .tc(tc_o[2]), .evt(evt_o[2]));

  task automatic check(input string tag, input int idx, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cfg%0d: observed %0d expected %0d (t=%0t)", tag, idx, obs, exp, $time);
    end
  endtask

  // Reference model: each configuration counts enabled cycles and steps every PRESCALE of them.
  task automatic model_edge(input bit r, input bit ld, input bit en, input bit ud, input int ci);
    for (int i = 0; i < N; i++) begin
      m_evt[i] = 0;
      if (!r) begin
        m_cnt[i] = 0;
        m_pre[i] = 0;
      end else if (ld) begin
        m_cnt[i] = (ci > CFG_MAX[i]) ? CFG_MAX[i] : ci;
        m_pre[i] = 0;
      end else if (en) begin
        m_pre[i] = m_pre[i] + 1;
        if (m_pre[i] == CFG_PRE[i]) begin
          m_pre[i] = 0;
          if (ud) begin
            if (m_cnt[i] == CFG_MAX[i]) begin
              m_evt[i] = 1;
              m_cnt[i] = CFG_SAT[i] ? CFG_MAX[i] : 0;
            end else begin
              m_cnt[i] = m_cnt[i] + 1;
            end
          end else begin
            if (m_cnt[i] == 0) begin
              m_evt[i] = 1;
              m_cnt[i] = CFG_SAT[i] ? 0 : CFG_MAX[i];
            end else begin
              m_cnt[i] = m_cnt[i] - 1;
            end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      check("cnt_out", i, int'(cnt[i]), m_cnt[i]);
      check("evt", i, int'(evt_o[i]), m_evt[i]);
      check("tc", i, int'(tc_o[i]),
            up_dn ? int'(m_cnt[i] == CFG_MAX[i]) : int'(m_cnt[i] == 0));
    end
  endtask

  // Drive on the falling edge, model the rising edge, check on the next falling edge.
  task automatic cyc(input bit r, input bit ld, input bit en, input bit ud, input int ci);
    rst_n  = r;
    load   = ld;
    enab   = en;
    up_dn  = ud;
    cnt_in = 5'(ci);
    @(posedge clk);
    model_edge(r, ld, en, ud, ci);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; enab = 1'b0; up_dn = 1'b1; cnt_in = '0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_evt[i] = 0;
    end
    @(negedge clk);

    // Reset state
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);

    // Load wins over enable; value visible after one edge
    cyc(1, 1, 1, 1, 'h15);
    cyc(1, 1, 1, 1, 'h0A);

    // Reset overrides load, then load after release
    cyc(1, 1, 0, 1, 'h1F);
    cyc(0, 1, 0, 1, 'h1F);
    cyc(1, 1, 0, 1, 'h1F);

    // Wrap up at the top, evt for one cycle, then wrap down from zero
    cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0);

    // Load clamps above the bound; saturating config holds at the top
    cyc(1, 1, 0, 1, 'h1C);
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 1, 0, 0);

    // Prescale: seven enabled cycles, two idle, then resume
    cyc(1, 1, 0, 1, 0);
    for (int k = 0; k < 7; k++) cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, 1, 0);

    // Load mid-prescale clears the partial count
    cyc(1, 1, 0, 1, 0);
    cyc(1, 0, 1, 1, 0);
    cyc(1, 1, 1, 1, 5);
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, 1, 0);

    // Reset mid-prescale discards the partial count
    cyc(1, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, 0, 0);

    // Saturate at the bottom repeatedly
    cyc(1, 1, 0, 0, 1);
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, 0, 0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 39) != 0),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) != 0),
          1'($urandom),
          int'($urandom_range(0, 31)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
